// File: rtl/controle_telas.sv
// Screen-sequencing controller for the VGA game path.
// Runs the game-level FSM (title, play, defeat, victory), gates the game
// logic and picks which renderer drives R/G/B. Screen changes happen only
// on the first pixel of vertical blanking so a visible frame never tears.
module controle_telas #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int HOLD_FRAMES = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        start_btn,
  input  logic        game_lost,
  input  logic        game_won,
  input  logic [23:0] title_rgb,
  input  logic [23:0] game_rgb,
  input  logic [23:0] defeat_rgb,
  input  logic [23:0] victory_rgb,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [1:0]  screen_sel,
  output logic        game_enable,
  output logic        game_reset_req
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    S_TITLE   = 2'd0,
    S_PLAY    = 2'd1,
    S_DEFEAT  = 2'd2,
    S_VICTORY = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic          start_prev;
  logic          start_req;
  logic          lost_req;
  logic          won_req;

  logic          frame_tick;
  logic          start_rise;
  logic          start_evt;
  logic          lost_evt;
  logic          won_evt;
  logic          visible;

  // First pixel of vertical blanking: exactly one cycle per frame.
  assign frame_tick = (h_counter == 10'd0) && (v_counter == 10'(V_ACTIVE));
  assign visible    = (h_counter < 10'(H_ACTIVE)) && (v_counter < 10'(V_ACTIVE));
  assign start_rise = start_btn & ~start_prev;

  // Pending event = latched event OR one arriving this cycle, gated by the
  // state in which it is meaningful; out-of-state events never latch.
  assign start_evt = start_req | (start_rise & (state == S_TITLE));
  assign lost_evt  = lost_req  | (game_lost  & (state == S_PLAY));
  assign won_evt   = won_req   | (game_won   & (state == S_PLAY));

  assign screen_sel = state;

  // Start button edge detector register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) start_prev <= 1'b0;
    else        start_prev <= start_btn;
  end

  // Game FSM with event latches, hold counter and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_TITLE;
      frame_cnt      <= '0;
      start_req      <= 1'b0;
      lost_req       <= 1'b0;
      won_req        <= 1'b0;
      game_enable    <= 1'b0;
      game_reset_req <= 1'b0;
    end else begin
      game_reset_req <= 1'b0;
      if (frame_tick) begin
        start_req <= 1'b0;
        lost_req  <= 1'b0;
        won_req   <= 1'b0;
        case (state)
          S_TITLE: begin
            if (start_evt) begin
              state          <= S_PLAY;
              frame_cnt      <= '0;
              game_enable    <= 1'b1;
              game_reset_req <= 1'b1;
            end
          end
          S_PLAY: begin
            // Loss wins over a simultaneous victory.
            if (lost_evt) begin
              state       <= S_DEFEAT;
              frame_cnt   <= '0;
              game_enable <= 1'b0;
            end else if (won_evt) begin
              state       <= S_VICTORY;
              frame_cnt   <= '0;
              game_enable <= 1'b0;
            end
          end
          default: begin
            // DEFEAT / VICTORY: entry tick is not counted, so leaving on the
            // tick that would make the count reach HOLD_FRAMES.
            if (frame_cnt == CW'(HOLD_FRAMES - 1)) begin
              state     <= S_TITLE;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        endcase
      end else begin
        start_req <= start_evt;
        lost_req  <= lost_evt;
        won_req   <= won_evt;
      end
    end
  end

  // Registered pixel mux; blanking is forced to black. During the tick cycle
  // the old state is still used, but that pixel is already in blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {R, G, B} <= 24'h0;
    end else if (!visible) begin
      {R, G, B} <= 24'h0;
    end else begin
      case (state)
        S_TITLE:  {R, G, B} <= title_rgb;
        S_PLAY:   {R, G, B} <= game_rgb;
        S_DEFEAT: {R, G, B} <= defeat_rgb;
        default:  {R, G, B} <= victory_rgb;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_telas.sv
// Testbench for controle_telas: directed scenarios followed by random
// traffic, all compared against a frame-level behavioural model.
module tb_controle_telas;

  localparam int HOLD = 3;

  logic        clk;
  logic        reset;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic        start_btn;
  logic        game_lost;
  logic        game_won;
  logic [23:0] title_rgb;
  logic [23:0] game_rgb;
  logic [23:0] defeat_rgb;
  logic [23:0] victory_rgb;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic [1:0]  screen_sel;
  logic        game_enable;
  logic        game_reset_req;

  controle_telas #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .h_counter(h_counter),
    .v_counter(v_counter),
    .start_btn(start_btn),
    .game_lost(game_lost),
    .game_won(game_won),
    .title_rgb(title_rgb),
    .game_rgb(game_rgb),
    .defeat_rgb(defeat_rgb),
    .victory_rgb(victory_rgb),
    .R(R),
    .G(G),
    .B(B),
    .screen_sel(screen_sel),
    .game_enable(game_enable),
    .game_reset_req(game_reset_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  // Reference model: which screen is up, which requests are pending this
  // frame, how many whole frames the end screen has been shown.
  int m_mode;
  bit m_start, m_lost, m_won, m_prev;
  int m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] src_of(input int mode);
    case (mode)
      0:       return title_rgb;
      1:       return game_rgb;
      2:       return defeat_rgb;
      default: return victory_rgb;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_lost = 0; m_won = 0; m_prev = 0; m_held = 0;
  endtask

  // Apply one pixel clock of stimulus, advance the model, compare outputs.
  task automatic step(input logic [9:0] h, input logic [9:0] v,
                      input logic st, input logic lo, input logic wo);
    bit tick, es, el, ew, pulse;
    int nm;
    logic [23:0] er;
    h_counter = h; v_counter = v; start_btn = st; game_lost = lo; game_won = wo;
    tick  = (h == 0) && (v == 480);
    er    = (h >= 640 || v >= 480) ? 24'h0 : src_of(m_mode);
    es    = m_start || (st && !m_prev && m_mode == 0);
    el    = m_lost  || (lo && m_mode == 1);
    ew    = m_won   || (wo && m_mode == 1);
    pulse = 0;
    nm    = m_mode;
    if (tick) begin
      if (m_mode == 0) begin
        if (es) begin nm = 1; pulse = 1; end
      end else if (m_mode == 1) begin
        if (el) nm = 2;
        else if (ew) nm = 3;
      end else begin
        m_held++;
        if (m_held == HOLD) nm = 0;
      end
      if (nm != m_mode) m_held = 0;
      m_start = 0; m_lost = 0; m_won = 0;
    end else begin
      m_start = es; m_lost = el; m_won = ew;
    end
    m_prev = st;
    m_mode = nm;
    @(posedge clk);
    #1;
    check("screen_sel", 32'(screen_sel), 32'(m_mode));
    check("game_enable", 32'(game_enable), 32'(m_mode == 1));
    check("game_reset_req", 32'(game_reset_req), 32'(pulse));
    check("rgb", 32'({R, G, B}), 32'(er));
    if (game_reset_req) n_pulses++;
  endtask

  task automatic tick_frame(input logic st);
    step(10'd0, 10'd480, st, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_rgb", 32'({R, G, B}), 32'h0);
    check("rst_screen_sel", 32'(screen_sel), 32'h0);
    check("rst_game_enable", 32'(game_enable), 32'h0);
    check("rst_reset_req", 32'(game_reset_req), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    h_counter = 10'd0; v_counter = 10'd0;
    start_btn = 1'b0; game_lost = 1'b0; game_won = 1'b0;
    title_rgb = 24'h112233; game_rgb = 24'h445566;
    defeat_rgb = 24'h778899; victory_rgb = 24'hAABBCC;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("init_rgb", 32'({R, G, B}), 32'h0);
    check("init_screen_sel", 32'(screen_sel), 32'h0);
    check("init_game_enable", 32'(game_enable), 32'h0);
    check("init_reset_req", 32'(game_reset_req), 32'h0);
    reset = 1'b1;

    // Title screen pixel.
    step(10'd10, 10'd10, 1'b0, 1'b0, 1'b0);
    check("title_R", 32'(R), 32'h11);
    check("title_G", 32'(G), 32'h22);
    check("title_B", 32'(B), 32'h33);

    // Start pressed mid-frame takes effect only at the frame tick.
    step(10'd0, 10'd100, 1'b1, 1'b0, 1'b0);
    step(10'd5, 10'd100, 1'b0, 1'b0, 1'b0);
    step(10'd0, 10'd479, 1'b0, 1'b0, 1'b0);
    check("title_before_tick", 32'(screen_sel), 32'h0);
    tick_frame(1'b0);
    check("enter_play_sel", 32'(screen_sel), 32'h1);
    check("enter_play_pulse", 32'(game_reset_req), 32'h1);
    step(10'd1, 10'd480, 1'b0, 1'b0, 1'b0);
    check("pulse_one_cycle", 32'(game_reset_req), 32'h0);
    step(10'd20, 10'd20, 1'b0, 1'b0, 1'b0);
    check("play_rgb", 32'({R, G, B}), 32'h445566);

    // Lost and won in the same frame: defeat has priority.
    step(10'd30, 10'd30, 1'b0, 1'b1, 1'b0);
    step(10'd40, 10'd40, 1'b0, 1'b0, 1'b1);
    tick_frame(1'b0);
    check("defeat_sel", 32'(screen_sel), 32'h2);
    check("defeat_enable", 32'(game_enable), 32'h0);
    step(10'd700, 10'd10, 1'b0, 1'b0, 1'b0);
    check("blank_rgb", 32'({R, G, B}), 32'h0);
    step(10'd50, 10'd50, 1'b0, 1'b0, 1'b0);
    check("defeat_rgb", 32'({R, G, B}), 32'h778899);

    // Hold for HOLD ticks; start is ignored meanwhile.
    step(10'd50, 10'd60, 1'b1, 1'b0, 1'b0);
    tick_frame(1'b0);
    check("hold1", 32'(screen_sel), 32'h2);
    step(10'd50, 10'd60, 1'b1, 1'b0, 1'b0);
    tick_frame(1'b1);
    check("hold2", 32'(screen_sel), 32'h2);
    tick_frame(1'b0);
    check("hold_done", 32'(screen_sel), 32'h0);

    // Stale win in title is not latched; held start gives one entry.
    step(10'd10, 10'd10, 1'b0, 1'b0, 1'b1);
    n_pulses = 0;
    step(10'd11, 10'd10, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      step(10'd100, 10'd200, 1'b1, 1'b0, 1'b0);
      tick_frame(1'b1);
    end
    check("stale_win_stays_play", 32'(screen_sel), 32'h1);
    check("single_pulse", 32'(n_pulses), 32'h1);

    // Victory, then reset mid-line.
    step(10'd60, 10'd60, 1'b0, 1'b0, 1'b1);
    tick_frame(1'b0);
    check("victory_sel", 32'(screen_sel), 32'h3);
    step(10'd70, 10'd70, 1'b0, 1'b0, 1'b0);
    check("victory_rgb", 32'({R, G, B}), 32'hAABBCC);
    async_reset();
    step(10'd70, 10'd70, 1'b0, 1'b0, 1'b0);
    check("after_reset_title", 32'(screen_sel), 32'h0);

    // Random traffic with frequent frame ticks and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      logic [9:0] h, v;
      if ($urandom_range(0, 63) == 0) begin
        title_rgb = 24'($urandom); game_rgb = 24'($urandom);
        defeat_rgb = 24'($urandom); victory_rgb = 24'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        h = 10'd0; v = 10'd480;
      end else begin
        h = 10'($urandom_range(0, 799));
        v = 10'($urandom_range(0, 524));
      end
      step(h, v, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 14) == 0));
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
